data_memory: RTL and testbench
==============================

DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter MEM_LATENCY, default 4: cycles from request acceptance to the access cycle; legal range is 2..15.
REQ-002 Parameter MEM_WORDS, default 256: number of 32-bit words; the word index is ADDRESS[log2(MEM_WORDS)+1:2].
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RESETN  input  1  asynchronous, active-low reset.
REQ-005 READ_WRITE  input  4  access command from the control unit; bit 3 = access valid.
REQ-006 ADDRESS  input  32  byte address, from the ALU result.
REQ-007 WRITE_DATA  input  32  store data; the low byte or halfword is used for SB and SH.
REQ-008 READ_DATA  output  32  extended load result; valid in the DONE cycle.
REQ-009 BUSYWAIT  output  1  stall request to the pipeline.
REQ-010 MISALIGNED  output  1  one-cycle pulse in DONE for a misaligned access; tied 0 when MISALIGN_TRAP_EN is undefined.

Function
REQ-011 READ_WRITE encoding SHALL be: LB=1000, LH=1001, LW=1010, SB=1011, LBU=1100, LHU=1101, SH=1110, SW=1111, any 0xxx=no access.
REQ-012 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-013 IDLE: if READ_WRITE[3]=1, capture READ_WRITE, ADDRESS and WRITE_DATA, load the counter with MEM_LATENCY-1, and go to BUSY; otherwise stay in IDLE.
REQ-014 BUSYWAIT SHALL be 1 combinationally in IDLE while READ_WRITE[3]=1, and SHALL be 1 throughout BUSY.
REQ-015 BUSYWAIT SHALL be 0 in DONE and in IDLE with no request.
REQ-016 BUSY: decrement the counter each cycle; on the edge where the counter equals 1, perform the access and go to DONE.
- Total BUSYWAIT-high cycles = MEM_LATENCY.
REQ-017 DONE SHALL last exactly one cycle, then go to IDLE unconditionally; READ_WRITE is ignored in DONE.
REQ-018 A new request is accepted in the cycle after DONE, so back-to-back accesses have one non-stall cycle between them.
REQ-019 Captured request fields SHALL NOT change during BUSY, even if the inputs change.
REQ-020 Addressing is little-endian.
- Byte lane = ADDRESS[1:0]; halfword lane = ADDRESS[1].
- Stores SHALL write only the addressed byte or halfword lanes.
REQ-021 LB and LH SHALL sign-extend; LBU and LHU SHALL zero-extend; LW returns the full word.
REQ-022 READ_DATA SHALL be registered.
- Updated on the access edge for loads; cleared to 0 for stores and for suppressed accesses.
- Holds its value until the next access edge.
REQ-023 Address bits above the word index SHALL be ignored, so the array wraps around.

Reset
REQ-024 When RESETN=0, the block SHALL immediately force state=IDLE, counter=0, READ_DATA=0 and MISALIGNED=0.
- BUSYWAIT then follows REQ-014.
REQ-025 Reset during BUSY SHALL abort the access; a store aborted before its access edge SHALL NOT modify memory.
REQ-026 The memory array SHALL NOT be reset; its contents are undefined until written.

Configuration
REQ-027 Macro DATA_MEMORY_MISALIGN_TRAP_EN selects how misaligned accesses are handled.
REQ-028 With the macro defined, a misaligned access SHALL still take the full latency; then MISALIGNED=1 in DONE, READ_DATA=0, and no write occurs.
- Misaligned = halfword access with ADDRESS[0]=1, or word access with ADDRESS[1:0]!=00.
REQ-029 With the macro undefined, the block SHALL ignore the low address bits that break alignment: bit 0 for halfwords, bits 1:0 for words. MISALIGNED SHALL be constant 0.

Structure
REQ-030 Shared package mem_pkg SHALL hold:
- the eight READ_WRITE code constants;
- the FSM state type;
- the MEM_LATENCY and MEM_WORDS defaults.
REQ-031 Sub-module data_memory_load_align SHALL be combinational.
- Inputs: word, lane, access code.
- Output: the 32-bit extended load value.
REQ-032 Store byte-enable generation SHALL stay in data_memory.

Verification
REQ-033 Reset, then SW 0xDEADBEEF at address 0x10 with MEM_LATENCY=4 -> BUSYWAIT high for 4 cycles, one DONE cycle with BUSYWAIT=0, READ_DATA=0.
REQ-034 After REQ-033: LW at 0x10 -> READ_DATA=0xDEADBEEF; LB at 0x13 -> 0xFFFFFFDE; LBU at 0x13 -> 0x000000DE; LH at 0x10 -> 0xFFFFBEEF; LHU at 0x12 -> 0x0000DEAD.
REQ-035 SB 0x12345677 at 0x11, then LW at 0x10 -> 0xDEAD77EF; SH 0x0000ABCD at 0x12, then LW -> 0xABCD77EF.
REQ-036 Change ADDRESS and WRITE_DATA during BUSY of SW to 0x20 -> only the word at 0x20 changes; assert RESETN=0 in BUSY of SW to 0x24 -> the word at 0x24 is unchanged and BUSYWAIT drops immediately.
REQ-037 LW at 0x22 -> with the macro: MISALIGNED=1 for one cycle and READ_DATA=0; without the macro: READ_DATA equals the word at 0x20 and MISALIGNED=0.
REQ-038 Two back-to-back LW requests held continuously -> DONE, IDLE(accept) sequence with exactly one BUSYWAIT=0 cycle between the accesses; address 0x410 with MEM_WORDS=256 -> accesses the word at 0x010.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data_memory block.
// Holds the READ_WRITE access codes, the controller FSM state type,
// the default latency/size parameters and the alignment helper.
package mem_pkg;

    localparam logic [3:0] RW_LB  = 4'b1000;
    localparam logic [3:0] RW_LH  = 4'b1001;
    localparam logic [3:0] RW_LW  = 4'b1010;
    localparam logic [3:0] RW_SB  = 4'b1011;
    localparam logic [3:0] RW_LBU = 4'b1100;
    localparam logic [3:0] RW_LHU = 4'b1101;
    localparam logic [3:0] RW_SH  = 4'b1110;
    localparam logic [3:0] RW_SW  = 4'b1111;

    localparam int DEF_MEM_LATENCY = 4;
    localparam int DEF_MEM_WORDS   = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Halfwords need an even address, words need a 4-byte aligned address.
    function automatic logic is_misaligned(input logic [3:0] code, input logic [1:0] lane);
        logic mis;
        case (code)
            RW_LH, RW_LHU, RW_SH: mis = lane[0];
            RW_LW, RW_SW:         mis = (lane != 2'b00);
            default:              mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/data_memory_if.sv
// Pipeline-to-data-memory bus.
//   READ_WRITE  : access command, bit 3 = valid
//   ADDRESS     : byte address
//   WRITE_DATA  : store data
//   READ_DATA   : extended load result (valid in DONE)
//   BUSYWAIT    : pipeline stall request
//   MISALIGNED  : misaligned-access pulse in DONE
// master = pipeline side, slave = memory side.
interface data_memory_if;
    logic [3:0]  READ_WRITE;
    logic [31:0] ADDRESS;
    logic [31:0] WRITE_DATA;
    logic [31:0] READ_DATA;
    logic        BUSYWAIT;
    logic        MISALIGNED;

    modport master (
        output READ_WRITE, ADDRESS, WRITE_DATA,
        input  READ_DATA, BUSYWAIT, MISALIGNED
    );

    modport slave (
        input  READ_WRITE, ADDRESS, WRITE_DATA,
        output READ_DATA, BUSYWAIT, MISALIGNED
    );
endinterface

// File: rtl/data_memory_load_align.sv
// Combinational load lane selection and sign/zero extension.
// Ports:
//   word  : full 32-bit memory word
//   lane  : ADDRESS[1:0] (bit 1 selects the halfword)
//   code  : READ_WRITE access code
//   value : extended 32-bit load result (0 for non-load codes)
module data_memory_load_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [3:0]  code,
    output logic [31:0] value
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign byte_s = word[8*lane +: 8];
    assign half_s = lane[1] ? word[31:16] : word[15:0];

    // Extend the selected lane according to the load flavour.
    always_comb begin
        value = 32'd0;
        case (code)
            RW_LB:   value = {{24{byte_s[7]}}, byte_s};
            RW_LBU:  value = {24'd0, byte_s};
            RW_LH:   value = {{16{half_s[15]}}, half_s};
            RW_LHU:  value = {16'd0, half_s};
            RW_LW:   value = word;
            default: value = 32'd0;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Multi-cycle data memory with a fixed access latency.
// A request is captured in IDLE, held in BUSY for MEM_LATENCY-1 cycles,
// performed on the last BUSY edge, and its result is presented in DONE.
// Ports:
//   CLK    : clock, rising edge
//   RESETN : asynchronous active-low reset
//   bus    : data_memory_if.slave (command, address, data, status)
// Parameters: MEM_LATENCY (2..15), MEM_WORDS (32-bit words).
// Macro DATA_MEMORY_MISALIGN_TRAP_EN: when defined, misaligned accesses are
// suppressed and flagged on MISALIGNED; otherwise the low address bits that
// break alignment are ignored and MISALIGNED stays 0.
module data_memory
    import mem_pkg::*;
#(
    parameter int MEM_LATENCY = DEF_MEM_LATENCY,
    parameter int MEM_WORDS   = DEF_MEM_WORDS
) (
    input  logic          CLK,
    input  logic          RESETN,
    data_memory_if.slave  bus
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    state_t      state_r, state_s;
    logic [3:0]  cnt_r;
    logic [3:0]  rw_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] rdata_r;
    logic        mis_r;

    logic [31:0] mem_r [MEM_WORDS];

    logic             accept_s, access_s, is_store_s, misaligned_s, we_s;
    logic [3:0]       be_s;
    logic [31:0]      wword_s, rword_s, load_s;
    logic [IDX_W-1:0] idx_s;
    logic             unused_s;

    // Upper address bits are dropped so the array wraps around.
    assign idx_s    = addr_r[IDX_W+1:2];
    assign unused_s = ^{addr_r[31:IDX_W+2]};
    assign rword_s  = mem_r[idx_s];

    assign is_store_s = (rw_r == RW_SB) || (rw_r == RW_SH) || (rw_r == RW_SW);

`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
    assign misaligned_s = is_misaligned(rw_r, addr_r[1:0]);
`else
    assign misaligned_s = 1'b0;
`endif

    assign we_s = access_s & is_store_s & ~misaligned_s;

    // Stall while a request is pending in IDLE and for all of BUSY.
    assign bus.BUSYWAIT   = (state_r == BUSY) | ((state_r == IDLE) & bus.READ_WRITE[3]);
    assign bus.READ_DATA  = rdata_r;
    assign bus.MISALIGNED = mis_r;

    data_memory_load_align u_load_align (
        .word  (rword_s),
        .lane  (addr_r[1:0]),
        .code  (rw_r),
        .value (load_s)
    );

    // Next-state logic; the access fires on the BUSY edge where the counter is 1.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        access_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.READ_WRITE[3]) begin
                    accept_s = 1'b1;
                    state_s  = BUSY;
                end else begin
                    state_s  = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == 4'd1) begin
                    access_s = 1'b1;
                    state_s  = DONE;
                end else begin
                    state_s  = BUSY;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Store byte enables and lane-replicated store data.
    always_comb begin
        be_s    = 4'b0000;
        wword_s = wdata_r;
        case (rw_r)
            RW_SB: begin
                be_s    = 4'b0001 << addr_r[1:0];
                wword_s = {4{wdata_r[7:0]}};
            end
            RW_SH: begin
                be_s    = addr_r[1] ? 4'b1100 : 4'b0011;
                wword_s = {2{wdata_r[15:0]}};
            end
            RW_SW: begin
                be_s    = 4'b1111;
                wword_s = wdata_r;
            end
            default: begin
                be_s    = 4'b0000;
                wword_s = wdata_r;
            end
        endcase
    end

    // Controller state, request capture, latency counter and registered outputs.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            rw_r    <= 4'd0;
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
            rdata_r <= 32'd0;
            mis_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                rw_r    <= bus.READ_WRITE;
                addr_r  <= bus.ADDRESS;
                wdata_r <= bus.WRITE_DATA;
                cnt_r   <= 4'(MEM_LATENCY - 1);
            end else if (state_r == BUSY) begin
                cnt_r   <= cnt_r - 4'd1;
            end else begin
                cnt_r   <= cnt_r;
            end
            if (access_s) begin
                rdata_r <= (is_store_s || misaligned_s) ? 32'd0 : load_s;
                mis_r   <= misaligned_s;
            end else begin
                mis_r   <= 1'b0;
            end
        end
    end

    // Memory array: not reset, written only in the addressed lanes.
    always_ff @(posedge CLK) begin
        if (we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_r[idx_s][8*i +: 8] <= wword_s[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: the stimulus process pushes the
// expected {MISALIGNED, READ_DATA} for every access; a monitor process
// detects each DONE cycle (BUSYWAIT falling after a stall) and compares.
module tb_data_memory;
    import mem_pkg::*;

    localparam int LAT = 4;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    logic [32:0] sb_q[$];

    data_memory_if bus();

    data_memory #(.MEM_LATENCY(LAT), .MEM_WORDS(256)) dut (
        .CLK    (clk),
        .RESETN (rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: counts stall cycles and checks each DONE cycle against the scoreboard.
    initial begin
        int busy_cnt;
        logic [32:0] exp;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                busy_cnt = 0;
            end else if (bus.BUSYWAIT) begin
                busy_cnt++;
            end else if (busy_cnt > 0) begin
                check("stall_len", 32'(busy_cnt), 32'(LAT));
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp = sb_q.pop_front();
                    check("read_data", bus.READ_DATA, exp[31:0]);
                    check("misaligned", {31'd0, bus.MISALIGNED}, {31'd0, exp[32]});
                end
                busy_cnt = 0;
            end
        end
    end

    // One access: drive in IDLE, drop the request after acceptance,
    // optionally change the inputs during BUSY, return in the DONE cycle.
    task automatic access(input logic [3:0] rw, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_mis,
                          input logic chg, input logic [31:0] a2, input logic [31:0] wd2);
        int n;
        @(posedge clk); #1;
        bus.READ_WRITE = rw;
        bus.ADDRESS    = a;
        bus.WRITE_DATA = wd;
        sb_q.push_back({exp_mis, exp_rd});
        @(posedge clk); #1;
        bus.READ_WRITE = 4'b0000;
        if (chg) begin
            bus.ADDRESS    = a2;
            bus.WRITE_DATA = wd2;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.BUSYWAIT && n < 40);
        if (n >= 40) check("done_timeout", 32'd1, 32'd0);
    endtask

    task automatic acc(input logic [3:0] rw, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd);
        access(rw, a, wd, exp_rd, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        logic [63:0] seen;
        logic [63:0] want;
        checks = 0;
        errors = 0;
        rstn = 1'b0;
        bus.READ_WRITE = 4'b0000;
        bus.ADDRESS    = 32'd0;
        bus.WRITE_DATA = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_read_data", bus.READ_DATA, 32'd0);
        check("reset_busywait", {31'd0, bus.BUSYWAIT}, 32'd0);
        check("reset_misaligned", {31'd0, bus.MISALIGNED}, 32'd0);
        rstn = 1'b1;

        // Word store and loads of every flavour.
        acc(RW_SW,  32'h10, 32'hDEADBEEF, 32'd0);
        acc(RW_LW,  32'h10, 32'd0, 32'hDEADBEEF);
        acc(RW_LB,  32'h13, 32'd0, 32'hFFFFFFDE);
        acc(RW_LBU, 32'h13, 32'd0, 32'h000000DE);
        acc(RW_LH,  32'h10, 32'd0, 32'hFFFFBEEF);
        acc(RW_LHU, 32'h12, 32'd0, 32'h0000DEAD);

        // Partial stores touch only their lanes.
        acc(RW_SB,  32'h11, 32'h12345677, 32'd0);
        acc(RW_LW,  32'h10, 32'd0, 32'hDEAD77EF);
        acc(RW_SH,  32'h12, 32'h0000ABCD, 32'd0);
        acc(RW_LW,  32'h10, 32'd0, 32'hABCD77EF);
        acc(RW_LB,  32'h11, 32'd0, 32'h00000077);
        acc(RW_LB,  32'h10, 32'd0, 32'hFFFFFFEF);
        acc(RW_LH,  32'h12, 32'd0, 32'hFFFFABCD);

        // Inputs changing during BUSY do not affect the captured request.
        acc(RW_SW,  32'h24, 32'h24242424, 32'd0);
        access(RW_SW, 32'h20, 32'hCAFEF00D, 32'd0, 1'b0, 1'b1, 32'h24, 32'h99999999);
        acc(RW_LW,  32'h20, 32'd0, 32'hCAFEF00D);
        acc(RW_LW,  32'h24, 32'd0, 32'h24242424);

        // Reset in BUSY aborts a store; BUSYWAIT drops at once.
        @(posedge clk); #1;
        bus.READ_WRITE = RW_SW;
        bus.ADDRESS    = 32'h24;
        bus.WRITE_DATA = 32'h55555555;
        @(posedge clk); #1;
        bus.READ_WRITE = 4'b0000;
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        check("abort_busywait", {31'd0, bus.BUSYWAIT}, 32'd0);
        check("abort_read_data", bus.READ_DATA, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        acc(RW_LW, 32'h24, 32'd0, 32'h24242424);

        // Misaligned word load.
`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
        access(RW_LW, 32'h22, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0);
`else
        access(RW_LW, 32'h22, 32'd0, 32'hCAFEF00D, 1'b0, 1'b0, 32'd0, 32'd0);
`endif

        // Back-to-back held request with address wrap (0x410 -> word at 0x10).
        @(posedge clk); #1;
        bus.READ_WRITE = RW_LW;
        bus.ADDRESS    = 32'h410;
        sb_q.push_back({1'b0, 32'hABCD77EF});
        sb_q.push_back({1'b0, 32'hABCD77EF});
        seen = 64'd0;
        want = 64'd0;
        for (int i = 0; i < 2*LAT + 2; i++) begin
            @(negedge clk);
            seen[i] = bus.BUSYWAIT;
            want[i] = !(i == LAT || i == 2*LAT + 1);
        end
        @(posedge clk); #1;
        bus.READ_WRITE = 4'b0000;
        check("b2b_busy_lo", seen[31:0], want[31:0]);
        check("b2b_busy_hi", seen[63:32], want[63:32]);

        repeat (LAT + 3) @(posedge clk);
        check("queue_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
